alu_tile_op_scheduler: RTL and testbench

//  Shares the tile's single ALU between the five request sources of the NoC tile: N, E, S, W and host.

---
 rtl/alu_tile_pkg.sv | 35 +++
 rtl/rr_arbiter_5.sv | 39 +++
 rtl/alu_tile_op_scheduler.sv | 176 +++++++++++++++++
 tb/tb_alu_tile_op_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_tile_pkg.sv
// Shared types and constants for the tile ALU scheduler and its arbiters.
//   req_idx_e     : requester index (0=N 1=E 2=S 3=W 4=host)
//   sched_state_e : scheduler FSM state
//   rr_next       : round-robin successor of a requester index (host wraps to N)
//   idx_onehot    : requester index to one-hot vector
package alu_tile_pkg;

    localparam int NUM_REQ = 5;
    localparam int DATA_W  = 64;
    localparam int CTRL_W  = 16;
    localparam int IDX_W   = 3;

    typedef enum logic [IDX_W-1:0] {
        REQ_N,
        REQ_E,
        REQ_S,
        REQ_W,
        REQ_HOST
    } req_idx_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_e;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(REQ_HOST)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_5.sv
// Purely combinational round-robin arbiter for the five tile requesters.
// The winner is the first set request bit found scanning upward from i_ptr,
// wrapping from index 4 back to 0.
//   i_req     : request vector, one bit per requester
//   i_ptr     : scan start index (expected range 0..NUM_REQ-1)
//   o_gnt     : one-hot grant, all zero when no request is set
//   o_gnt_idx : index of the granted requester, 0 when none
module rr_arbiter_5
    import alu_tile_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx
);

    logic [IDX_W:0] w_pos;
    logic           w_found;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Position k steps after the pointer, folded back into 0..NUM_REQ-1.
            w_pos = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
                w_found                   = 1'b1;
                o_gnt[w_pos[IDX_W-1:0]]   = 1'b1;
                o_gnt_idx                 = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_tile_op_scheduler.sv
// Shares the tile's single ALU between the N, E, S, W and host requesters.
// One operation is in flight at a time: IDLE accepts a round-robin winner and
// latches its operands, ISSUE strobes the ALU, WAIT collects the result (or
// aborts after TIMEOUT cycles) and returns a registered response to the owner.
//
// Handshake: a requester holds req_valid with stable operands; the operation
// is taken in the cycle where req_valid[i] && req_ready[i]. req_ready is
// combinational, one-hot, and only ever asserted in IDLE. alu_valid is a
// single-cycle strobe with no back-pressure; alu_done is only sampled in WAIT.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_a/b/ctrl     per-requester operation, packed i*W +: W
//   req_ready                  one-hot accept
//   alu_valid/alu_a/b/ctrl     issue strobe and latched operands
//   alu_done/alu_result        ALU completion
//   resp_valid/data/err        one-hot registered response, err = timeout
//   busy, owner_id             FSM not idle, current owner index
//   dbg_state                  FSM state for observation
module alu_tile_op_scheduler
    import alu_tile_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      alu_valid,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [CTRL_W-1:0]         alu_ctrl,
    input  logic                      alu_done,
    input  logic [DATA_W-1:0]         alu_result,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic                      busy,
    output logic [2:0]                owner_id,
    output sched_state_e              dbg_state
);

    sched_state_e        r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [7:0]          r_tmo_cnt;
    logic [IDX_W-1:0]    r_owner;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [NUM_REQ-1:0]  r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;
    logic                r_resp_err;

    sched_state_e        w_state_nx;
    logic                w_accept;
    logic [7:0]          w_tmo_nx;
    logic [IDX_W-1:0]    w_ptr_nx;
    logic [NUM_REQ-1:0]  w_resp_valid_nx;
    logic [DATA_W-1:0]   w_resp_data_nx;
    logic                w_resp_err_nx;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [CTRL_W-1:0]   w_sel_ctrl;

    rr_arbiter_5 u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    // Operand mux for the current arbitration winner.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_sel_a    = req_a[i*DATA_W +: DATA_W];
                w_sel_b    = req_b[i*DATA_W +: DATA_W];
                w_sel_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
            end
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_accept        = 1'b0;
        w_tmo_nx        = r_tmo_cnt;
        w_ptr_nx        = r_rr_ptr;
        w_resp_valid_nx = '0;
        w_resp_err_nx   = 1'b0;
        w_resp_data_nx  = r_resp_data;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_accept   = 1'b1;
                    w_state_nx = ISSUE;
                end
            end
            ISSUE: begin
                w_tmo_nx   = '0;
                w_state_nx = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    w_resp_valid_nx = idx_onehot(r_owner);
                    w_resp_data_nx  = alu_result;
                    w_ptr_nx        = rr_next(r_owner);
                    w_state_nx      = IDLE;
                end else begin
                    w_tmo_nx = r_tmo_cnt + 8'd1;
                    // The counter reaches TIMEOUT at the end of the TIMEOUT-th
                    // WAIT cycle; the abort response lands in the next cycle.
                    if (r_tmo_cnt == 8'(TIMEOUT - 1)) begin
                        w_resp_valid_nx = idx_onehot(r_owner);
                        w_resp_err_nx   = 1'b1;
                        w_resp_data_nx  = '0;
                        w_ptr_nx        = rr_next(r_owner);
                        w_state_nx      = IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_tmo_cnt    <= '0;
            r_owner      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_ctrl       <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_rr_ptr     <= w_ptr_nx;
            r_tmo_cnt    <= w_tmo_nx;
            r_resp_valid <= w_resp_valid_nx;
            r_resp_data  <= w_resp_data_nx;
            r_resp_err   <= w_resp_err_nx;
            if (w_accept) begin
                r_owner <= w_gnt_idx;
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_ctrl  <= w_sel_ctrl;
            end
        end
    end

    assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
    assign alu_valid  = (r_state == ISSUE);
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_ctrl   = r_ctrl;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state != IDLE);
    assign owner_id   = busy ? r_owner : 3'd0;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_tile_op_scheduler.sv
// Self-checking bench for alu_tile_op_scheduler. Stimulus tasks push the
// expected response of every accepted operation into exp_q; a monitor pops
// and compares whenever resp_valid is seen. Cycle-exact checks (ready, issue,
// response timing) are made inline by the driver task.
module tb_alu_tile_op_scheduler;
    import alu_tile_pkg::*;

    localparam int RW = 1 + NUM_REQ + DATA_W;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      alu_valid;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [CTRL_W-1:0]         alu_ctrl;
    logic                      alu_done;
    logic [DATA_W-1:0]         alu_result;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_err;
    logic                      busy;
    logic [2:0]                owner_id;
    sched_state_e              dbg_state;

    logic [DATA_W-1:0] tb_a [NUM_REQ];
    logic [DATA_W-1:0] tb_b [NUM_REQ];
    logic [CTRL_W-1:0] tb_c [NUM_REQ];

    int n_checks = 0;
    int n_fail   = 0;
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] mon_e;

    alu_tile_op_scheduler #(.TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .req_ready  (req_ready),
        .alu_valid  (alu_valid),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .owner_id   (owner_id),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*DATA_W +: DATA_W]    = tb_a[i];
            req_b[i*DATA_W +: DATA_W]    = tb_b[i];
            req_ctrl[i*CTRL_W +: CTRL_W] = tb_c[i];
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: actual valid=%b data=%0h required=no response",
                         resp_valid, resp_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_scoreboard", 72'({resp_err, resp_valid, resp_data}), 72'(mon_e));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"},  72'(req_ready),  72'(0));
        chk({tag, "_alu_valid"},  72'(alu_valid),  72'(0));
        chk({tag, "_alu_a"},      72'(alu_a),      72'(0));
        chk({tag, "_alu_b"},      72'(alu_b),      72'(0));
        chk({tag, "_alu_ctrl"},   72'(alu_ctrl),   72'(0));
        chk({tag, "_resp_valid"}, 72'(resp_valid), 72'(0));
        chk({tag, "_resp_data"},  72'(resp_data),  72'(0));
        chk({tag, "_resp_err"},   72'(resp_err),   72'(0));
        chk({tag, "_busy"},       72'(busy),       72'(0));
        chk({tag, "_owner_id"},   72'(owner_id),   72'(0));
        chk({tag, "_state"},      72'(dbg_state),  72'(IDLE));
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT in IDLE; returns at the negedge of the
    // response cycle (DUT back in IDLE, ready for the next accept).
    task automatic run_op(input logic [NUM_REQ-1:0] mask, input int exp_idx,
                          input logic [DATA_W-1:0] result, input int done_wait,
                          input bit timeout, input bit hold, input bit spur_issue);
        logic [NUM_REQ-1:0] oh;
        oh = NUM_REQ'(1) << exp_idx;
        req_valid = mask;
        #1;
        chk("req_ready_grant", 72'(req_ready), 72'(oh));
        chk("busy_at_accept",  72'(busy),      72'(0));
        exp_q.push_back({timeout, oh, timeout ? 64'h0 : result});
        @(negedge clk);
        if (!hold) req_valid = '0;
        chk("req_ready_issue", 72'(req_ready), 72'(0));
        chk("alu_valid_issue", 72'(alu_valid), 72'(1));
        chk("alu_a_issue",     72'(alu_a),     72'(tb_a[exp_idx]));
        chk("alu_b_issue",     72'(alu_b),     72'(tb_b[exp_idx]));
        chk("alu_ctrl_issue",  72'(alu_ctrl),  72'(tb_c[exp_idx]));
        chk("owner_id_issue",  72'(owner_id),  72'(exp_idx));
        if (spur_issue) alu_done = 1'b1;
        if (timeout) begin
            repeat (255) @(negedge clk);
            chk("tmo_busy_last_wait", 72'(busy),       72'(1));
            chk("tmo_no_early_resp",  72'(resp_valid), 72'(0));
            chk("tmo_alu_valid_low",  72'(alu_valid),  72'(0));
            @(negedge clk);
        end else begin
            for (int k = 0; k < done_wait; k++) begin
                @(negedge clk);
                alu_done = 1'b0;
                chk("wait_busy",          72'(busy),       72'(1));
                chk("wait_no_resp",       72'(resp_valid), 72'(0));
                chk("wait_alu_valid_low", 72'(alu_valid),  72'(0));
            end
            @(negedge clk);
            alu_done   = 1'b1;
            alu_result = result;
            @(negedge clk);
            alu_done = 1'b0;
        end
        chk("resp_valid_timing", 72'(resp_valid), 72'(oh));
        chk("resp_err_flag",     72'(resp_err),   72'(timeout));
        chk("busy_after_resp",   72'(busy),       72'(0));
        chk("owner_id_idle",     72'(owner_id),   72'(0));
        chk("alu_a_stable",      72'(alu_a),      72'(tb_a[exp_idx]));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int ord [6];
        rst        = 1'b1;
        req_valid  = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tb_a[i] = 64'h10 + 64'(i);
            tb_b[i] = 64'h20 + 64'(i);
            tb_c[i] = 16'h0100 + 16'(i);
        end
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // 1. single op from N: 5 + 7 = 12
        tb_a[0] = 64'd5;
        tb_b[0] = 64'd7;
        tb_c[0] = 16'h0001;
        run_op(5'b00001, 0, 64'd12, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("resp_pulse_one_cycle", 72'(resp_valid), 72'(0));
        chk("resp_data_holds",      72'(resp_data),  72'(12));
        tb_a[0] = 64'h10;
        tb_b[0] = 64'h20;
        tb_c[0] = 16'h0100;

        // 2. fairness from a fresh pointer, all five requesting continuously
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ord = '{0, 1, 2, 3, 4, 0};
        for (int j = 0; j < 6; j++) begin
            run_op(5'b11111, ord[j], 64'hA0 + 64'(j), 0, 1'b0, 1'b1, 1'b0);
        end
        req_valid = '0;
        @(negedge clk);

        // 3. wrap/skip: S moves the pointer to 3, then {E,N} scans 3,4,0 -> N, then E
        run_op(5'b00100, 2, 64'h33, 0, 1'b0, 1'b0, 1'b0);
        run_op(5'b00011, 0, 64'h30, 0, 1'b0, 1'b0, 1'b0);
        run_op(5'b00011, 1, 64'h31, 0, 1'b0, 1'b0, 1'b0);

        // 4. timeout on E, then N accepted normally (pointer at 2 scans to 0)
        run_op(5'b00010, 1, 64'h0, 0, 1'b1, 1'b0, 1'b0);
        run_op(5'b00001, 0, 64'h44, 1, 1'b0, 1'b0, 1'b0);

        // 5. spurious done in IDLE and in ISSUE is ignored
        alu_done   = 1'b1;
        alu_result = 64'hDEAD;
        @(negedge clk);
        alu_done = 1'b0;
        chk("spur_idle_no_resp", 72'(resp_valid), 72'(0));
        chk("spur_idle_busy",    72'(busy),       72'(0));
        @(negedge clk);
        chk("spur_idle_no_resp2", 72'(resp_valid), 72'(0));
        run_op(5'b01000, 3, 64'h55, 2, 1'b0, 1'b0, 1'b1);

        // 6. reset mid-WAIT of a host op (pointer was 4), then {host,E} -> E
        req_valid = 5'b10000;
        #1;
        chk("rstmid_ready_host", 72'(req_ready), 72'(5'b10000));
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("rstmid_in_wait", 72'(dbg_state), 72'(WAIT));
        rst = 1'b1;
        #1;
        check_idle_outputs("rstmid");
        @(negedge clk);
        rst = 1'b0;
        run_op(5'b10010, 1, 64'h66, 0, 1'b0, 1'b0, 1'b0);
        run_op(5'b10000, 4, 64'h77, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 72'(exp_q.size()), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
